// File: rtl/pc_sequencer.sv
// pc_sequencer
//
// Fetch-side program-counter controller. Owns the PC register, issues
// instruction-memory requests through a req/ack handshake, and applies
// traps, redirects, stalls and halt/resume. Every accepted fetch is
// reported downstream as a one-cycle registered pulse.
//
// Ports:
//   clk            system clock, all state updates on the rising edge
//   reset          asynchronous active-low reset
//   start          leave IDLE/HALTED and begin fetching
//   stall          downstream cannot accept instructions
//   halt           stop fetching after the current cycle
//   redirect_valid load redirect_pc as the next fetch address
//   redirect_pc    branch/jump target
//   trap           fetch from TRAP_VEC next, saving the current PC in epc
//   imem_req       fetch request (high only in FETCH)
//   imem_addr      fetch address (always equals pc)
//   imem_ack       memory accepts the request; transfer = imem_req && imem_ack
//   pc             current fetch address register
//   fetch_valid    one-cycle pulse, one per accepted fetch
//   fetch_pc       address of the fetch flagged by fetch_valid
//   epc            PC captured at the most recent trap
//   state          IDLE=0, FETCH=1, STALL=2, HALTED=3
module pc_sequencer #(
  parameter int                     PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_VEC = '0,
  parameter logic [PC_WIDTH-1:0]    TRAP_VEC  = PC_WIDTH'(32'h100),
  parameter logic [PC_WIDTH-1:0]    INCR      = PC_WIDTH'(1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stall,
  input  logic                halt,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                trap,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  output logic [PC_WIDTH-1:0] pc,
  output logic                fetch_valid,
  output logic [PC_WIDTH-1:0] fetch_pc,
  output logic [PC_WIDTH-1:0] epc,
  output logic [1:0]          state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] STALL  = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  logic [1:0]          state_reg,       state_next;
  logic [PC_WIDTH-1:0] pc_reg,          pc_next;
  logic [PC_WIDTH-1:0] epc_reg,         epc_next;
  logic                fetch_valid_reg, fetch_valid_next;
  logic [PC_WIDTH-1:0] fetch_pc_reg,    fetch_pc_next;
  logic                transfer;

  // A handshake only counts while requesting; acks in other states are ignored.
  assign transfer = (state_reg == FETCH) && imem_ack;

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    epc_next         = epc_reg;
    fetch_valid_next = 1'b0;
    fetch_pc_next    = fetch_pc_reg;

    case (state_reg)
      IDLE: begin
        if (trap) begin
          epc_next   = pc_reg;
          pc_next    = TRAP_VEC;
          state_next = FETCH;
        end else if (start) begin
          state_next = FETCH;
        end
      end

      FETCH: begin
        // Trap and redirect discard any coincident transfer: the fetched
        // word belongs to a path that is being abandoned.
        if (trap) begin
          epc_next = pc_reg;
          pc_next  = TRAP_VEC;
        end else if (redirect_valid) begin
          pc_next = redirect_pc;
        end else if (transfer) begin
          fetch_valid_next = 1'b1;
          fetch_pc_next    = pc_reg;
          pc_next          = pc_reg + INCR;  // wraps modulo 2^PC_WIDTH
          if (halt)       state_next = HALTED;
          else if (stall) state_next = STALL;
        end else if (halt) begin
          state_next = HALTED;
        end else if (stall) begin
          state_next = STALL;
        end
      end

      STALL: begin
        // A trap/redirect while stalled retargets the PC but keeps the stall.
        if (trap) begin
          epc_next = pc_reg;
          pc_next  = TRAP_VEC;
        end else if (redirect_valid) begin
          pc_next = redirect_pc;
        end else if (halt) begin
          state_next = HALTED;
        end else if (!stall) begin
          state_next = FETCH;
        end
      end

      HALTED: begin
        if (trap) begin
          epc_next   = pc_reg;
          pc_next    = TRAP_VEC;
          state_next = FETCH;
        end else if (redirect_valid) begin
          pc_next = redirect_pc;
        end else if (start) begin
          state_next = FETCH;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_VEC;
      epc_reg         <= '0;
      fetch_valid_reg <= 1'b0;
      fetch_pc_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      epc_reg         <= epc_next;
      fetch_valid_reg <= fetch_valid_next;
      fetch_pc_reg    <= fetch_pc_next;
    end
  end

  assign imem_req    = (state_reg == FETCH);
  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign epc         = epc_reg;
  assign fetch_valid = fetch_valid_reg;
  assign fetch_pc    = fetch_pc_reg;
  assign state       = state_reg;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch-side controller for the program counter.
- Owns the PC register and sequences instruction-memory requests through a req/ack handshake.
- Applies redirects (branch/jump), traps, stalls and halt/resume, and reports each accepted fetch downstream.
- Sits between the core control unit and instruction memory; replaces the free-running PC with a controlled one.

Parameters:
- PC_WIDTH, 32, width of PC and all address ports.
- RESET_VEC, 0, PC value loaded on reset.
- TRAP_VEC, 32'h100, PC value loaded on trap.
- INCR, 1, PC increment per accepted fetch (word addressing).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  leave IDLE/HALTED and begin fetching.
- stall  in  1  downstream cannot accept instructions; suspend requests.
- halt  in  1  stop fetching after the current cycle.
- redirect_valid  in  1  load redirect_pc as next fetch address.
- redirect_pc  in  PC_WIDTH  branch/jump target.
- trap  in  1  force fetch from TRAP_VEC; save current PC.
- imem_req  out  1  fetch request, combinational from state (1 only in FETCH).
- imem_addr  out  PC_WIDTH  equals pc.
- imem_ack  in  1  memory accepts request; transfer = imem_req && imem_ack.
- pc  out  PC_WIDTH  current fetch address register.
- fetch_valid  out  1  registered one-cycle pulse per accepted fetch.
- fetch_pc  out  PC_WIDTH  address of the fetch flagged by fetch_valid.
- epc  out  PC_WIDTH  PC captured at last trap.
- state  out  2  IDLE=0, FETCH=1, STALL=2, HALTED=3.

Behaviour:
- Reset (async, while reset=0):
  - state=IDLE, pc=RESET_VEC, epc=0, fetch_valid=0, fetch_pc=0.
  - imem_req=0.
  - Takes effect immediately mid-operation; any in-flight transfer is dropped.
- Arithmetic: next sequential pc = (pc + INCR) mod 2^PC_WIDTH. All-ones + 1 wraps to 0 with no error flag.
- fetch_valid defaults to 0 every cycle; it is 1 only in the cycle after a counted transfer.
- IDLE:
  - imem_req=0.
  - start -> FETCH.
  - trap -> pc=TRAP_VEC, epc=pc, then FETCH.
- FETCH: imem_req=1. Per-cycle priority is trap > redirect_valid > transfer > halt > stall.
  - trap: epc<=pc, pc<=TRAP_VEC, stay FETCH. A coincident transfer is discarded (no fetch_valid).
  - redirect_valid (no trap): pc<=redirect_pc, stay FETCH. A coincident transfer is discarded.
  - Transfer (no trap/redirect): fetch_valid<=1, fetch_pc<=pc, pc<=pc+INCR.
    - halt also high -> HALTED after the transfer.
    - Else stall high -> STALL.
    - Else stay FETCH.
  - No transfer, halt=1 -> HALTED, pc unchanged.
  - No transfer, stall=1 -> STALL, pc unchanged.
  - Back-to-back acks give one fetch per cycle; throughput is 1/cycle.
- STALL:
  - imem_req=0; pc is held.
  - trap or redirect updates pc/epc as in FETCH; state remains STALL.
  - halt -> HALTED.
  - Else stall=0 -> FETCH.
- HALTED:
  - imem_req=0; pc is held.
  - trap -> pc=TRAP_VEC, epc=pc, then FETCH.
  - redirect updates pc and stays HALTED.
  - start -> FETCH, resuming at pc.
- imem_ack outside FETCH is ignored.
- Latency: accepted fetch to fetch_valid is 1 cycle. Redirect/trap to first imem_addr at the new target is 1 cycle.

Test Plan:
- Reset release, start=1, imem_ack held 1 for 4 cycles -> imem_addr 0,1,2,3; fetch_valid pulses with fetch_pc 0,1,2,3; pc=4.
- pc=5 in FETCH, redirect_valid=1, redirect_pc=0x40, imem_ack=1 same cycle -> no fetch_valid; next cycle imem_addr=0x40.
- pc=0x20, trap=1 and redirect_valid=1 together -> epc=0x20, pc=0x100, redirect ignored, state FETCH.
- FETCH, stall=1 and imem_ack=0 for 3 cycles -> state STALL, imem_req=0, pc unchanged; stall=0 -> FETCH, same pc re-requested.
- pc=32'hFFFF_FFFF, ack -> fetch_pc=FFFF_FFFF, pc=0. Then halt=1 with ack -> one more fetch (fetch_pc=0), pc=1, HALTED; start -> resumes at 1.
- Assert reset low mid-FETCH with ack high -> outputs return to reset values in the same cycle, no fetch_valid.
